slice_scheduler: RTL and testbench



---
 rtl/slice_scheduler_pkg.sv | 21 ++
 rtl/slice_scheduler_timer.sv | 35 +++
 rtl/slice_scheduler.sv | 124 ++++++++++++
 tb/tb_slice_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_scheduler_pkg.sv
// Shared definitions for the slice scheduler: FSM state encoding and a
// width helper for the grant index.
package slice_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    // Ceiling log2, used to size the grant index from the requester count
    function automatic int unsigned sched_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/slice_scheduler_timer.sv
// Slice timer: loadable up-counter that measures the current grant and
// flags its last permitted cycle.
module slice_timer #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic         inc,
    input  logic [N-1:0] len,
    output logic [N-1:0] cnt,
    output logic         terminal
);

    logic [N-1:0] limit;

    // Load starts a new slice; a zero length is promoted to one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            limit <= N'(1);
        end else if (load) begin
            cnt   <= '0;
            limit <= (len == '0) ? N'(1) : len;
        end else if (clear) begin
            cnt   <= '0;
        end else if (inc) begin
            cnt   <= cnt + N'(1);
        end
    end

    assign terminal = (cnt == (limit - N'(1)));

endmodule

// File: rtl/slice_scheduler.sv
// Round-robin time-slice scheduler: grants one requester at a time for at
// most slice_len cycles, with a one-cycle dead gap between grants.
module slice_scheduler
    import slice_scheduler_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned N    = 4,
    localparam int unsigned IDW  = sched_clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    input  logic [N-1:0]    slice_len,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic [N-1:0]    slice_cnt,
    output logic            expire
);

    state_e          state, state_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  id_d;
    logic            busy_d;
    logic            expire_d;
    logic [IDW-1:0]  last_id, last_d;
    logic            found;
    logic [IDW-1:0]  win;
    logic            early;
    logic            terminal;
    logic            tload, tclr, tinc;

    slice_timer #(.N(N)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tload),
        .clear    (tclr),
        .inc      (tinc),
        .len      (slice_len),
        .cnt      (slice_cnt),
        .terminal (terminal)
    );

    // Round-robin pick: first set request after the last owner, wrapping
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = 32'(last_id) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign early = done[gnt_id] | ~req[gnt_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            expire  <= 1'b0;
            last_id <= IDW'(NREQ - 1);
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            gnt_id  <= id_d;
            busy    <= busy_d;
            expire  <= expire_d;
            last_id <= last_d;
        end
    end

    // Next state and next output values; idle and gap arbitrate identically
    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        id_d     = gnt_id;
        busy_d   = busy;
        expire_d = 1'b0;
        last_d   = last_id;
        tload    = 1'b0;
        tclr     = 1'b0;
        tinc     = 1'b0;
        case (state)
            S_IDLE, S_GAP: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (found) begin
                    gnt_d   = NREQ'(1) << win;
                    id_d    = win;
                    busy_d  = 1'b1;
                    tload   = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (early || terminal) begin
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    last_d   = gnt_id;
                    expire_d = terminal & ~early;
                    tclr     = 1'b1;
                    state_d  = S_GAP;
                end else begin
                    tinc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a requester-level reference model.
module tb_slice_scheduler;

    localparam int NREQ = 4;
    localparam int N    = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   done;
    logic [3:0]   slice_len;
    logic [3:0]   gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic [3:0]   slice_cnt;
    logic         expire;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource and for how long
    int m_owner;
    int m_id;
    int m_last;
    int m_elapsed;
    int m_limit;
    bit m_expire;

    slice_scheduler #(.NREQ(NREQ), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .slice_len (slice_len),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .slice_cnt (slice_cnt),
        .expire    (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_id      = 0;
        m_last    = NREQ - 1;
        m_elapsed = 0;
        m_limit   = 1;
        m_expire  = 1'b0;
    endtask

    task automatic model_step();
        bit rel;
        bit tmo;
        if (m_owner >= 0) begin
            rel      = done[m_owner] || !req[m_owner];
            tmo      = (m_elapsed + 1 == m_limit);
            m_expire = tmo && !rel;
            if (rel || tmo) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else begin
            m_expire = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (m_owner < 0 && req[c]) begin
                    m_owner   = c;
                    m_id      = c;
                    m_elapsed = 0;
                    m_limit   = (slice_len == 0) ? 1 : int'(slice_len);
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("gnt_id",    32'(gnt_id),    32'(m_id));
        chk("busy",      32'(busy),      32'(m_owner >= 0));
        chk("slice_cnt", 32'(slice_cnt), (m_owner >= 0) ? 32'(m_elapsed) : 32'd0);
        chk("expire",    32'(expire),    32'(m_expire));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle_out();
        req  = 4'b0000;
        done = 4'b0000;
        repeat (3) cycle();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        done      = 4'b0000;
        slice_len = 4'd5;
        model_reset();

        // Reset held with all requests pending
        #1;
        compare_model();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t1_rst_gnt", 32'(gnt), 32'd0);
        end
        rst = 1'b0;
        cycle();
        chk("t1_first_gnt", 32'(gnt), 32'h1);
        chk("t1_first_id",  32'(gnt_id), 32'd0);
        idle_out();

        // Timeout on a lone requester
        req = 4'b0001; slice_len = 4'd5;
        cycle();
        for (int c = 0; c < 5; c++) begin
            chk("t2_gnt", 32'(gnt), 32'h1);
            chk("t2_cnt", 32'(slice_cnt), 32'(c));
            cycle();
        end
        chk("t2_gap_gnt", 32'(gnt), 32'd0);
        chk("t2_gap_exp", 32'(expire), 32'd1);
        cycle();
        chk("t2_regrant", 32'(gnt), 32'h1);
        idle_out();

        // Round robin over all four
        do_reset();
        req = 4'b1111; slice_len = 4'd3;
        cycle();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 3; k++) begin
                chk("t3_gnt", 32'(gnt), 32'd1 << (g % 4));
                cycle();
            end
            if (g < 4) begin
                chk("t3_gap_exp", 32'(expire), 32'd1);
                cycle();
            end
        end
        idle_out();

        // Early release by the owner; a non-owner done is ignored
        do_reset();
        req = 4'b0110; slice_len = 4'd8;
        cycle();
        chk("t4_gnt0", 32'(gnt), 32'h2);
        done = 4'b1000;
        cycle();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        chk("t4_cnt1", 32'(slice_cnt), 32'd1);
        done = 4'b0010;
        cycle();
        chk("t4_gap_gnt", 32'(gnt), 32'd0);
        chk("t4_gap_exp", 32'(expire), 32'd0);
        done = 4'b0000;
        cycle();
        chk("t4_next", 32'(gnt), 32'h4);
        idle_out();

        // Zero slice length gives single-cycle grants
        do_reset();
        req = 4'b0001; slice_len = 4'd0;
        cycle();
        for (int r = 0; r < 3; r++) begin
            chk("t5_len0_gnt", 32'(gnt), 32'h1);
            cycle();
            chk("t5_len0_exp", 32'(expire), 32'd1);
            cycle();
        end
        idle_out();

        // Slice length change mid-grant applies only to the next grant
        req = 4'b0001; slice_len = 4'd5;
        cycle();
        cycle();
        chk("t5_chg_cnt1", 32'(slice_cnt), 32'd1);
        slice_len = 4'd2;
        for (int c = 2; c < 5; c++) begin
            cycle();
            chk("t5_chg_hold", 32'(gnt), 32'h1);
        end
        cycle();
        chk("t5_chg_exp", 32'(expire), 32'd1);
        cycle();
        cycle();
        chk("t5_short_cnt", 32'(slice_cnt), 32'd1);
        cycle();
        chk("t5_short_exp", 32'(expire), 32'd1);

        // Dropping the request terminates without expire
        slice_len = 4'd5;
        repeat (3) cycle();
        chk("t5_drop_cnt", 32'(slice_cnt), 32'd2);
        req = 4'b0000;
        cycle();
        chk("t5_drop_gnt", 32'(gnt), 32'd0);
        chk("t5_drop_exp", 32'(expire), 32'd0);
        idle_out();

        // Asynchronous reset between edges
        do_reset();
        req = 4'b0001; slice_len = 4'd8;
        repeat (4) cycle();
        chk("t6_cnt3", 32'(slice_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_async_gnt",  32'(gnt), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_cnt",  32'(slice_cnt), 32'd0);
        req = 4'b1010;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t6_after", 32'(gnt), 32'h2);
        idle_out();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            done      = 4'($urandom) & 4'($urandom) & 4'($urandom);
            slice_len = 4'($urandom_range(0, 15));
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
